eth_rx_frame_fifo: RTL and testbench
====================================

Name: eth_rx_frame_fifo

Overview:
- Store-and-forward receive frame buffer between the MAC receive AXIS output and the ETH receive input (rgmii_rx_* of the ETH top level).
- Accepts bytes at line rate with no backpressure and holds each frame until its last byte.
- Discards frames flagged bad by the MAC (user on last), frames that overflow the buffer, and runts.
- Forwards only complete good frames, so the UDP parser never sees a partial or errored frame.

Parameters:
- DEPTH_LOG2, 11, log2 of buffer entries; usable capacity is 2^DEPTH_LOG2 - 1 bytes.
- MIN_FRAME_LEN, 14, minimum byte count of an accepted frame; shorter frames are dropped.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk_125m  in  1  system clock.
- sys_rst  in  1  reset; synchronous, active-high.
- s_rx_data  in  8  byte from the MAC.
- s_rx_valid  in  1  byte valid.
- s_rx_last  in  1  last byte of the frame.
- s_rx_user  in  1  MAC error flag; sampled only with s_rx_last.
- s_rx_ready  out  1  constantly 1 (the MAC cannot stall).
- m_rx_data  out  8  byte to ETH rgmii_rx_data.
- m_rx_valid  out  1  output valid.
- m_rx_last  out  1  last byte of a forwarded frame.
- m_rx_user  out  1  constantly 0 (bad frames never reach the output).
- m_rx_ready  in  1  downstream ready (ETH rgmii_rx_ready).
- good_cnt  out  CNT_WIDTH  count of frames committed.
- bad_cnt  out  CNT_WIDTH  count of frames dropped for user=1 or runt.
- ovf_cnt  out  CNT_WIDTH  count of frames dropped for overflow.

Behaviour:
- Reset: all pointers 0, state IDLE, m_rx_valid=0, m_rx_last=0, m_rx_data=0, counters 0, s_rx_ready=1, m_rx_user=0.
- Storage: 2^DEPTH_LOG2 x 9-bit RAM {last, data}; synchronous read, 1-cycle latency.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth: wr_ptr, wr_commit, rd_ptr.
- Full when wr_ptr+1 == rd_ptr. Empty when rd_ptr == wr_commit.
- Write FSM has states IDLE, RECV, DROP. IDLE and RECV both accept bytes; RECV means at least one byte of the current frame has been written.
- Byte counter len counts bytes of the current frame and saturates at 2^16-1.
- Handshake in IDLE/RECV, when s_rx_valid=1:
  - If not full: write at wr_ptr, increment wr_ptr and len, go to RECV.
  - If full: set wr_ptr=wr_commit and go to DROP. If this byte is also last, count ovf and go to IDLE.
- Frame end in IDLE/RECV, when s_rx_valid=1 and s_rx_last=1 and the byte was written:
  - If s_rx_user=1 or len+1 < MIN_FRAME_LEN: set wr_ptr=wr_commit, bad_cnt+1.
  - Otherwise: wr_commit = wr_ptr+1, i.e. the new write pointer, last byte included; good_cnt+1.
  - Then return to IDLE and clear len.
- DROP: discard every byte. On s_rx_valid and s_rx_last, ovf_cnt+1 and go to IDLE. The user flag is ignored in DROP, and ovf_cnt has priority over bad_cnt.
- Rollback on drop restores all space used by the dropped frame. Committed frames are never disturbed.
- Read side is a first-word-fall-through output register fed from the RAM with one-entry prefetch:
  - m_rx_valid rises 2 cycles after wr_commit changes from empty.
  - Data/last are held stable while m_rx_valid=1 and m_rx_ready=0.
  - With m_rx_ready held 1, one byte is delivered per cycle with no bubbles, including across frame boundaries.
- Simultaneous write commit and read in the same cycle are allowed. The full flag uses the rd_ptr registered that cycle, which is conservative.
- Counters wrap modulo 2^CNT_WIDTH.
- sys_rst mid-frame discards the buffer contents and any frame in progress. Bytes arriving after reset release but before the next frame start are written as a new frame; the MAC guarantees frame alignment after reset.

Test Plan:
- Good frame: 64-byte frame 0x00..0x3F, user=0, m_rx_ready=1.
  - m_rx_valid rises 2 cycles after the input last.
  - Output is 64 consecutive bytes 0x00..0x3F with m_rx_last on 0x3F.
  - good_cnt=1.
- Bad frame: 64-byte frame with s_rx_user=1 on last, followed by a good 60-byte frame.
  - Only the 60-byte frame is output.
  - bad_cnt=1, good_cnt=1.
- Runt: 10-byte frame → no output, bad_cnt=1. A 14-byte frame → forwarded.
- Overflow: DEPTH_LOG2=6, m_rx_ready=0, send a 40-byte frame then an 80-byte frame.
  - The 80-byte frame is dropped and ovf_cnt=1.
  - After m_rx_ready=1, exactly the 40 bytes of frame 1 are output.
  - A subsequent 40-byte frame is then accepted.
- Backpressure and wrap: DEPTH_LOG2=6, 20 frames of 50 bytes each with random m_rx_ready toggling.
  - The output byte stream matches the input exactly.
  - m_rx_data/last are stable while valid and not ready.
  - Pointers wrap at least 15 times; good_cnt=20.
- Reset mid-frame: assert sys_rst for 1 cycle after byte 30 of a 64-byte frame.
  - All outputs and counters go to 0, and nothing from that frame is output.
  - The next 64-byte good frame is output intact.

Source files
------------

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer: holds each MAC frame until its last byte,
// drops bad, runt and overflowing frames, and forwards only complete good frames.
module eth_rx_frame_fifo #(
  parameter int DEPTH_LOG2    = 11,
  parameter int MIN_FRAME_LEN = 14,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk_125m,
  input  logic                 sys_rst,
  input  logic [7:0]           s_rx_data,
  input  logic                 s_rx_valid,
  input  logic                 s_rx_last,
  input  logic                 s_rx_user,
  output logic                 s_rx_ready,
  output logic [7:0]           m_rx_data,
  output logic                 m_rx_valid,
  output logic                 m_rx_last,
  output logic                 m_rx_user,
  input  logic                 m_rx_ready,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt,
  output logic [CNT_WIDTH-1:0] ovf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LEN_W = 16;
  localparam logic [LEN_W:0] MIN_LEN = (LEN_W + 1)'(MIN_FRAME_LEN);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_e;

  logic [8:0]           mem [DEPTH];
  logic [8:0]           ram_q;
  wr_state_e            state_q;
  ptr_t                 wr_ptr_q, wr_commit_q, rd_ptr_q, rd_ptr_d, wr_ptr_inc;
  logic [LEN_W-1:0]     len_q;
  logic [CNT_WIDTH-1:0] good_q, bad_q, ovf_q;
  logic                 ram_vld_q, ram_vld_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 full, empty, wr_en, runt;
  logic                 out_take, ram_take, do_read;

  // Full compares against the registered read pointer, so a same-cycle read is not credited yet.
  assign wr_ptr_inc = wr_ptr_q + 1'b1;
  assign full       = (wr_ptr_inc == rd_ptr_q);
  assign empty      = (rd_ptr_q == wr_commit_q);
  assign wr_en      = s_rx_valid && (state_q != DROP) && !full;
  assign runt       = (({1'b0, len_q} + 1'b1) < MIN_LEN);

  // NOTE: the buffer RAM and its read register carry no reset so they map onto block RAM;
  // every consumer is qualified by a reset-cleared valid or pointer, so stale contents never leak.
  always_ff @(posedge clk_125m) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {s_rx_last, s_rx_data};
    end
    if (do_read) begin
      ram_q <= mem[rd_ptr_q];
    end
  end

  // Write-side frame FSM: pointers, length and statistics move together per accepted byte.
  always_ff @(posedge clk_125m) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      len_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      ovf_q       <= '0;
    end else if (s_rx_valid) begin
      unique case (state_q)
        IDLE, RECV: begin
          if (full) begin
            wr_ptr_q <= wr_commit_q;
            len_q    <= '0;
            if (s_rx_last) begin
              ovf_q   <= ovf_q + 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= DROP;
            end
          end else if (s_rx_last) begin
            len_q   <= '0;
            state_q <= IDLE;
            if (s_rx_user || runt) begin
              wr_ptr_q <= wr_commit_q;
              bad_q    <= bad_q + 1'b1;
            end else begin
              wr_ptr_q    <= wr_ptr_inc;
              wr_commit_q <= wr_ptr_inc;
              good_q      <= good_q + 1'b1;
            end
          end else begin
            wr_ptr_q <= wr_ptr_inc;
            len_q    <= (len_q == '1) ? len_q : len_q + 1'b1;
            state_q  <= RECV;
          end
        end
        DROP: begin
          if (s_rx_last) begin
            ovf_q   <= ovf_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-stage read pipe: RAM read register, then the output register that holds under stall.
  always_comb begin
    out_take  = !m_valid_q || m_rx_ready;
    ram_take  = !ram_vld_q || out_take;
    do_read   = !empty && ram_take;
    rd_ptr_d  = do_read ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_vld_d = do_read || (ram_vld_q && !out_take);
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (out_take) begin
      m_valid_d = ram_vld_q;
      m_last_d  = ram_vld_q && ram_q[8];
      if (ram_vld_q) begin
        m_data_d = ram_q[7:0];
      end
    end
  end

  always_ff @(posedge clk_125m) begin
    if (sys_rst) begin
      rd_ptr_q  <= '0;
      ram_vld_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      ram_vld_q <= ram_vld_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
    end
  end

  assign s_rx_ready = 1'b1;
  assign m_rx_user  = 1'b0;
  assign m_rx_data  = m_data_q;
  assign m_rx_valid = m_valid_q;
  assign m_rx_last  = m_last_q;
  assign good_cnt   = good_q;
  assign bad_cnt    = bad_q;
  assign ovf_cnt    = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench: a large-buffer and a small-buffer instance share one frame driver;
// expected output bytes are queued at stimulus time and popped by per-instance monitors.
module tb_eth_rx_frame_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_user;
  logic       rdy_big, rdy_small_set, tog_en, rdy_small;

  logic [7:0]  b_data, s_data;
  logic        b_valid, b_last, b_user, b_sready;
  logic        s_valid, s_last, s_user, s_sready;
  logic [15:0] b_good, b_bad, b_ovf, s_good, s_bad, s_ovf;

  logic [8:0] q_big[$];
  logic [8:0] q_small[$];
  int n_vec = 0;
  int n_err = 0;

  always #4 clk = ~clk;

  eth_rx_frame_fifo #(.DEPTH_LOG2(11), .MIN_FRAME_LEN(14), .CNT_WIDTH(16)) dut_big (
    .clk_125m(clk), .sys_rst(rst),
    .s_rx_data(in_data), .s_rx_valid(in_valid && !sel), .s_rx_last(in_last),
    .s_rx_user(in_user), .s_rx_ready(b_sready),
    .m_rx_data(b_data), .m_rx_valid(b_valid), .m_rx_last(b_last), .m_rx_user(b_user),
    .m_rx_ready(rdy_big), .good_cnt(b_good), .bad_cnt(b_bad), .ovf_cnt(b_ovf)
  );

  eth_rx_frame_fifo #(.DEPTH_LOG2(6), .MIN_FRAME_LEN(14), .CNT_WIDTH(16)) dut_small (
    .clk_125m(clk), .sys_rst(rst),
    .s_rx_data(in_data), .s_rx_valid(in_valid && sel), .s_rx_last(in_last),
    .s_rx_user(in_user), .s_rx_ready(s_sready),
    .m_rx_data(s_data), .m_rx_valid(s_valid), .m_rx_last(s_last), .m_rx_user(s_user),
    .m_rx_ready(rdy_small), .good_cnt(s_good), .bad_cnt(s_bad), .ovf_cnt(s_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input logic s);
    return s ? q_small.size() : q_big.size();
  endfunction

  // Random ready for the small instance while toggling is enabled.
  initial begin
    rdy_small = 1'b1;
    forever begin
      @(posedge clk); #2;
      rdy_small = tog_en ? 1'($urandom_range(0, 1)) : rdy_small_set;
    end
  end

  // Monitor for the large instance.
  initial begin
    logic       stall;
    logic [8:0] prev, exp;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall && b_valid) check("big_stall_stable", {23'b0, b_last, b_data}, {23'b0, prev});
        if (b_valid && rdy_big) begin
          check("big_out_expected", {31'b0, q_big.size() > 0}, 32'd1);
          if (q_big.size() > 0) begin
            exp = q_big.pop_front();
            check("big_byte", {23'b0, b_last, b_data}, {23'b0, exp});
          end
        end
        stall = b_valid && !rdy_big;
        prev  = {b_last, b_data};
      end
    end
  end

  // Monitor for the small instance.
  initial begin
    logic       stall;
    logic [8:0] prev, exp;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall && s_valid) check("small_stall_stable", {23'b0, s_last, s_data}, {23'b0, prev});
        if (s_valid && rdy_small) begin
          check("small_out_expected", {31'b0, q_small.size() > 0}, 32'd1);
          if (q_small.size() > 0) begin
            exp = q_small.pop_front();
            check("small_byte", {23'b0, s_last, s_data}, {23'b0, exp});
          end
        end
        stall = s_valid && !rdy_small;
        prev  = {s_last, s_data};
      end
    end
  end

  initial begin
    #640000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives len bytes start, start+1, ...; term=0 leaves the frame open (no last byte).
  task automatic send_frame(input logic s, input int len, input logic [7:0] start,
                            input logic user, input bit term, input bit expect_out);
    logic [7:0] b;
    logic       l;
    sel = s;
    for (int i = 0; i < len; i++) begin
      b = start + 8'(i);
      l = term && (i == len - 1);
      in_data  = b;
      in_last  = l;
      in_user  = user && l;
      in_valid = 1'b1;
      if (expect_out) begin
        if (s) q_small.push_back({l, b});
        else   q_big.push_back({l, b});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_user  = 1'b0;
  endtask

  task automatic wait_drain(input logic s, input string name);
    int n = 0;
    while (qsize(s) != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, qsize(s), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string name, input logic [15:0] g, input logic [15:0] b,
                            input logic [15:0] o, input int eg, input int eb, input int eo);
    check({name, "_good"}, {16'b0, g}, eg);
    check({name, "_bad"},  {16'b0, b}, eb);
    check({name, "_ovf"},  {16'b0, o}, eo);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
    rdy_big = 1'b1; rdy_small_set = 1'b1; tog_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state on both instances.
    check("rst_big_valid", {31'b0, b_valid}, 0);
    check("rst_big_last",  {31'b0, b_last}, 0);
    check("rst_big_data",  {24'b0, b_data}, 0);
    check("rst_big_sready", {31'b0, b_sready}, 1);
    check("rst_big_user",  {31'b0, b_user}, 0);
    chk_counts("rst_big", b_good, b_bad, b_ovf, 0, 0, 0);
    check("rst_small_valid", {31'b0, s_valid}, 0);
    check("rst_small_sready", {31'b0, s_sready}, 1);
    chk_counts("rst_small", s_good, s_bad, s_ovf, 0, 0, 0);

    // Good 64-byte frame; valid rises on the second edge after the one sampling last.
    send_frame(1'b0, 64, 8'h00, 1'b0, 1'b1, 1'b1);
    check("lat_edge0_valid", {31'b0, b_valid}, 0);
    @(posedge clk); #1;
    check("lat_edge1_valid", {31'b0, b_valid}, 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", {31'b0, b_valid}, 1);
    wait_drain(1'b0, "t1_drain");
    chk_counts("t1", b_good, b_bad, b_ovf, 1, 0, 0);

    // Bad-flagged frame followed by a good 60-byte frame.
    pulse_reset();
    send_frame(1'b0, 64, 8'h80, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 60, 8'h10, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, "t2_drain");
    chk_counts("t2", b_good, b_bad, b_ovf, 1, 1, 0);

    // Runts at 10 and 13 bytes are dropped; exactly 14 bytes is forwarded.
    pulse_reset();
    send_frame(1'b0, 10, 8'hA0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 13, 8'hB0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 14, 8'hC0, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, "t3_drain");
    chk_counts("t3", b_good, b_bad, b_ovf, 1, 2, 0);

    // Reset after byte 30 of an open frame clears everything; next frame is intact.
    send_frame(1'b0, 30, 8'h55, 1'b0, 1'b0, 1'b0);
    pulse_reset();
    check("t6_valid", {31'b0, b_valid}, 0);
    check("t6_data",  {24'b0, b_data}, 0);
    check("t6_last",  {31'b0, b_last}, 0);
    chk_counts("t6_rst", b_good, b_bad, b_ovf, 0, 0, 0);
    send_frame(1'b0, 64, 8'h20, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b0, "t6_drain");
    chk_counts("t6", b_good, b_bad, b_ovf, 1, 0, 0);

    // Overflow on the 64-entry instance; user on the dropped frame's last is ignored.
    pulse_reset();
    rdy_small_set = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(1'b1, 40, 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(1'b1, 80, 8'h60, 1'b1, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk_counts("t4_ovf", s_good, s_bad, s_ovf, 1, 0, 1);
    rdy_small_set = 1'b1;
    wait_drain(1'b1, "t4_drain");
    send_frame(1'b1, 40, 8'h40, 1'b0, 1'b1, 1'b1);
    wait_drain(1'b1, "t4_after_drain");
    chk_counts("t4", s_good, s_bad, s_ovf, 2, 0, 1);

    // 20 frames of 50 bytes with random ready: about 16 pointer wraps.
    pulse_reset();
    tog_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int n = 0;
      while (q_small.size() > 10 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("t5_space", {31'b0, q_small.size() <= 10}, 1);
      send_frame(1'b1, 50, 8'(f * 7), 1'b0, 1'b1, 1'b1);
    end
    tog_en = 1'b0;
    rdy_small_set = 1'b1;
    wait_drain(1'b1, "t5_drain");
    chk_counts("t5", s_good, s_bad, s_ovf, 20, 0, 0);
    check("end_small_user", {31'b0, s_user}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
